// File: rtl/renode_input_monitor.sv
// rtl/renode_input_monitor.sv - synchronises GPIO lines and reports each level change as an
// (index, value) event on a valid/ready stream with round-robin arbitration between lines.
module renode_input_monitor #(
  parameter int InputsCount = 1,
  parameter int SyncStages  = 2,
  localparam int IndexWidth = (InputsCount > 1) ? $clog2(InputsCount) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [InputsCount-1:0] inputs,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [IndexWidth-1:0]  event_index,
  output logic                   event_value,
  output logic [InputsCount-1:0] pending
);

  logic [InputsCount-1:0] synced;
  logic [InputsCount-1:0] reported_q, reported_d;
  logic [InputsCount-1:0] slot_mask;
  logic [InputsCount-1:0] pending_w;
  logic                   event_valid_q, event_valid_d;
  logic                   event_value_q, event_value_d;
  logic [IndexWidth-1:0]  event_index_q, event_index_d;
  logic [IndexWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IndexWidth-1:0]  sel_idx;
  logic                   sel_found;
  logic                   accept;

  generate
    if (SyncStages == 0) begin : g_nosync
      assign synced = inputs;
    end else begin : g_sync
      logic [InputsCount-1:0] sync_q [SyncStages];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= inputs;
          for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign synced = sync_q[SyncStages-1];
    end
  endgenerate

  // The line sitting in the slot is never pending, so it cannot be chosen again while
  // it is held or in the cycle it is accepted.
  assign accept    = event_valid_q & event_ready;
  assign slot_mask = event_valid_q ? (InputsCount'(1) << event_index_q) : '0;
  assign pending_w = (synced ^ reported_q) & ~slot_mask;

  always_comb begin
    int j;
    int nxt;
    j             = 0;
    nxt           = 0;
    sel_found     = 1'b0;
    sel_idx       = '0;
    reported_d    = reported_q;
    event_valid_d = event_valid_q;
    event_index_d = event_index_q;
    event_value_d = event_value_q;
    rr_ptr_d      = rr_ptr_q;

    for (int k = 0; k < InputsCount; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= InputsCount) j = j - InputsCount;
      if (!sel_found && |(pending_w & (InputsCount'(1) << j))) begin
        sel_found = 1'b1;
        sel_idx   = IndexWidth'(j);
      end
    end

    if (accept) begin
      reported_d = (reported_q & ~slot_mask) | (event_value_q ? slot_mask : '0);
    end

    if (!event_valid_q || accept) begin
      if (sel_found) begin
        event_valid_d = 1'b1;
        event_index_d = sel_idx;
        event_value_d = |(synced & (InputsCount'(1) << sel_idx));
        nxt           = int'(sel_idx) + 1;
        if (nxt >= InputsCount) nxt = 0;
        rr_ptr_d      = IndexWidth'(nxt);
      end else begin
        event_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reported_q    <= '0;
      event_valid_q <= 1'b0;
      event_index_q <= '0;
      event_value_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      reported_q    <= reported_d;
      event_valid_q <= event_valid_d;
      event_index_q <= event_index_d;
      event_value_q <= event_value_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_index = event_index_q;
  assign event_value = event_value_q;
  assign pending     = pending_w;

endmodule

// File: tb/tb_renode_input_monitor.sv
// tb/tb_renode_input_monitor.sv - directed self-checking bench for renode_input_monitor
// (4 lines, 2 synchroniser stages).
module tb_renode_input_monitor;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] inputs = 4'b0;
  logic       event_valid;
  logic       event_ready = 1'b1;
  logic [1:0] event_index;
  logic       event_value;
  logic [3:0] pending;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0] idx_log[$];
  logic       val_log[$];

  renode_input_monitor #(.InputsCount(4), .SyncStages(2)) dut (
    .clk(clk), .resetn(resetn), .inputs(inputs),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_index(event_index), .event_value(event_value), .pending(pending)
  );

  always #5 clk = ~clk;

  // Transfer log: the DUT updates with non-blocking assignments, so pre-edge values are seen here.
  always @(posedge clk) begin
    if (resetn && event_valid && event_ready) begin
      idx_log.push_back(event_index);
      val_log.push_back(event_value);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    inputs = 4'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idx_log.delete();
    val_log.delete();
  endtask

  task automatic test_reset();
    int valid_cycles;
    resetn = 1'b0;
    inputs = 4'b0;
    event_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({event_valid, event_index, event_value, pending} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b idx=%0d val=%b pending=%b, want all 0",
               event_valid, event_index, event_value, pending);
    end
    resetn = 1'b1;
    idx_log.delete();
    val_log.delete();
    valid_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (event_valid !== 1'b0 || pending !== 4'b0) valid_cycles++;
    end
    tests_run++;
    if (valid_cycles != 0 || idx_log.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %0d active cycles, %0d transfers, want 0 and 0",
               valid_cycles, idx_log.size());
    end
  endtask

  task automatic test_single_edge();
    inputs = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b0 || pending !== 4'b0100) begin
      tests_failed++;
      $display("FAIL latency_early: got valid=%b pending=%b after 2 edges, want 0 and 0100",
               event_valid, pending);
    end
    @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b1 || event_index !== 2'd2 || event_value !== 1'b1 || pending !== 4'b0) begin
      tests_failed++;
      $display("FAIL latency_3rd_edge: got valid=%b idx=%0d val=%b pending=%b, want 1 2 1 0000",
               event_valid, event_index, event_value, pending);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (idx_log.size() != 1 || event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rise_count: got %0d transfers valid=%b, want 1 and 0", idx_log.size(), event_valid);
    end
    inputs = 4'b0000;
    repeat (6) @(negedge clk);
    tests_run++;
    if (idx_log.size() != 2 || idx_log[idx_log.size()-1] !== 2'd2 || val_log[val_log.size()-1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_fall: got %0d transfers last idx=%0d val=%b, want 2 transfers idx=2 val=0",
               idx_log.size(), idx_log[idx_log.size()-1], val_log[val_log.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_idx [3];
    exp_idx = '{2'd0, 2'd1, 2'd3};
    do_reset();
    event_ready = 1'b1;
    inputs = 4'b1011;
    repeat (2) @(negedge clk);
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      tests_run++;
      if (event_valid !== 1'b1 || event_index !== exp_idx[e] || event_value !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_event%0d: got valid=%b idx=%0d val=%b, want 1 %0d 1",
                 e, event_valid, event_index, event_value, exp_idx[e]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b0 || idx_log.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_drain: got valid=%b transfers=%0d, want 0 and 3", event_valid, idx_log.size());
    end
  endtask

  task automatic test_hold_stable();
    int unstable;
    do_reset();
    event_ready = 1'b0;
    inputs = 4'b0010;
    repeat (3) @(negedge clk);
    unstable = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) inputs = 4'b0000;
      if (event_valid !== 1'b1 || event_index !== 2'd1 || event_value !== 1'b1) unstable++;
      @(negedge clk);
    end
    tests_run++;
    if (unstable != 0 || idx_log.size() != 0) begin
      tests_failed++;
      $display("FAIL hold_stable: got %0d unstable cycles %0d transfers, want 0 and 0", unstable, idx_log.size());
    end
    event_ready = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (idx_log.size() != 2 || idx_log[0] !== 2'd1 || val_log[0] !== 1'b1 ||
        idx_log[1] !== 2'd1 || val_log[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release: got %0d transfers, want (1,1) then (1,0)", idx_log.size());
    end
    tests_run++;
    if (event_valid !== 1'b0 || pending !== 4'b0) begin
      tests_failed++;
      $display("FAIL hold_idle: got valid=%b pending=%b, want 0 and 0000", event_valid, pending);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    event_ready = 1'b0;
    inputs = 4'b0010;
    repeat (3) @(negedge clk);
    inputs = 4'b0011;
    @(negedge clk);
    inputs = 4'b0010;
    repeat (6) @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b1 || event_index !== 2'd1 || pending !== 4'b0) begin
      tests_failed++;
      $display("FAIL coalesce_busy: got valid=%b idx=%0d pending=%b, want 1 1 0000",
               event_valid, event_index, pending);
    end
    event_ready = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (idx_log.size() != 1 || idx_log[0] !== 2'd1 || event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL coalesce_events: got %0d transfers valid=%b, want 1 transfer of line 1 and valid 0",
               idx_log.size(), event_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    event_ready = 1'b0;
    inputs = 4'b1000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b1 || event_index !== 2'd3) begin
      tests_failed++;
      $display("FAIL mid_preload: got valid=%b idx=%0d, want 1 3", event_valid, event_index);
    end
    resetn = 1'b0;
    #1;
    tests_run++;
    if (event_valid !== 1'b0 || event_index !== 2'd0 || event_value !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_async_clear: got valid=%b idx=%0d val=%b, want 0 0 0",
               event_valid, event_index, event_value);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    event_ready = 1'b1;
    idx_log.delete();
    val_log.delete();
    repeat (2) @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_resend_early: got valid=%b after 2 edges, want 0", event_valid);
    end
    @(negedge clk);
    tests_run++;
    if (event_valid !== 1'b1 || event_index !== 2'd3 || event_value !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_resend: got valid=%b idx=%0d val=%b, want 1 3 1",
               event_valid, event_index, event_value);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (idx_log.size() != 1 || idx_log[0] !== 2'd3 || val_log[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_resend_count: got %0d transfers, want exactly one (3,1)", idx_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_back_to_back();
    test_hold_stable();
    test_coalesce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
